sk_add_arbiter: RTL

//  Shares one external 16-bit Sklansky prefix adder between two requesters.

---
 rtl/sk_add_arbiter_if.sv | 29 ++
 rtl/sk_add_arbiter.sv | 102 ++++++++++
 2 files changed

// File: rtl/sk_add_arbiter_if.sv
// sk_add_arbiter_if: request and response channels between two operand sources,
// the shared-adder arbiter and the result consumer.
interface sk_add_arbiter_if #(
   parameter int WORD_W = 16,
   parameter int NWORDS = 4
);
   localparam int OPW = WORD_W * NWORDS;
   logic [1:0]     req_valid;
   logic [1:0]     req_ready;
   logic [OPW-1:0] req0_a;
   logic [OPW-1:0] req0_b;
   logic           req0_ci;
   logic [OPW-1:0] req1_a;
   logic [OPW-1:0] req1_b;
   logic           req1_ci;
   logic           rsp_valid;
   logic           rsp_ready;
   logic           rsp_id;
   logic [OPW-1:0] rsp_sum;
   logic           rsp_co;
   modport master (
      output req_valid, req0_a, req0_b, req0_ci, req1_a, req1_b, req1_ci, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_co
   );
   modport slave (
      input  req_valid, req0_a, req0_b, req0_ci, req1_a, req1_b, req1_ci, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_co
   );
endinterface

// File: rtl/sk_add_arbiter.sv
// sk_add_arbiter: shares one external WORD_W adder between two requesters, issuing
// an NWORDS-slice add LSW first with a registered ripple carry between slices.
module sk_add_arbiter #(
   parameter int WORD_W = 16,
   parameter int NWORDS = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   sk_add_arbiter_if.slave   bus,
   output logic [WORD_W-1:0] add_a,
   output logic [WORD_W-1:0] add_b,
   output logic              add_ci,
   input  logic [WORD_W-1:0] add_s,
   input  logic              add_co
);
   localparam int OPW = WORD_W * NWORDS;
   localparam int KW = NWORDS > 1 ? $clog2(NWORDS) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NWORDS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state_q, state_d;
   logic [KW-1:0] k_q, k_d;
   logic [OPW-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic ci_q, ci_d, id_q, id_d, last_q, last_d, carry_q, carry_d, co_q, co_d;
   logic gnt, accept;

   // on contention the requester not served last time wins
   assign gnt = (bus.req_valid == 2'b11) ? ~last_q : bus.req_valid[1];
   assign accept = (state_q == IDLE) && (|bus.req_valid);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         k_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         ci_q    <= 1'b0;
         id_q    <= 1'b0;
         last_q  <= 1'b1;
         carry_q <= 1'b0;
         co_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         ci_q    <= ci_d;
         id_q    <= id_d;
         last_q  <= last_d;
         carry_q <= carry_d;
         co_q    <= co_d;
      end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = RUN;
         RUN:     if (k_q == K_LAST) state_d = DONE;
         DONE:    if (bus.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      k_d     = k_q;
      a_d     = a_q;
      b_d     = b_q;
      ci_d    = ci_q;
      id_d    = id_q;
      last_d  = last_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      co_d    = co_q;
      if (accept) begin
         k_d    = '0;
         a_d    = gnt ? bus.req1_a : bus.req0_a;
         b_d    = gnt ? bus.req1_b : bus.req0_b;
         ci_d   = gnt ? bus.req1_ci : bus.req0_ci;
         id_d   = gnt;
         last_d = gnt;
      end
      if (state_q == RUN) begin
         k_d = k_q + KW'(1);
         sum_d[k_q*WORD_W +: WORD_W] = add_s;
         carry_d = add_co;
         if (k_q == K_LAST) co_d = add_co;
      end
   end

   always_comb begin
      bus.req_ready = accept ? (gnt ? 2'b10 : 2'b01) : 2'b00;
      add_a         = (state_q == RUN) ? a_q[k_q*WORD_W +: WORD_W] : '0;
      add_b         = (state_q == RUN) ? b_q[k_q*WORD_W +: WORD_W] : '0;
      add_ci        = (state_q == RUN) ? ((k_q == '0) ? ci_q : carry_q) : 1'b0;
      bus.rsp_valid = state_q == DONE;
      bus.rsp_id    = id_q;
      bus.rsp_sum   = sum_q;
      bus.rsp_co    = co_q;
   end
endmodule
